// File: rtl/usb_rx_fifo_if.sv
// Byte-stream bundle between the MUACM RX stream, the FIFO and the ACIA RX port.
//
// Handshake: a byte moves on a rising clk edge when both valid and ready are
// high at that edge. valid never depends on ready and ready never depends on
// valid. Data is only meaningful while valid is high.
//
// master: the side that feeds upstream bytes and drains the head byte.
// slave:  the FIFO itself.
interface usb_rx_fifo_if #(
  parameter int AW = 6
);
  logic [7:0]  in_data;
  logic        in_val;
  logic        in_rdy;
  logic [7:0]  out_data;
  logic        out_val;
  logic        out_rdy;
  logic [AW:0] level;
  logic        almost_full;

  modport master (
    output in_data, in_val, out_rdy,
    input  in_rdy, out_data, out_val, level, almost_full
  );

  modport slave (
    input  in_data, in_val, out_rdy,
    output in_rdy, out_data, out_val, level, almost_full
  );
endinterface

// File: rtl/usb_rx_fifo.sv
// First-word-fall-through byte FIFO between the USB-CDC RX stream and the CPU
// ACIA RX port. Ready/valid on both sides are decoded from the registered
// level, so no input reaches in_rdy or out_val combinationally. out_data is
// read straight from the storage array at the read pointer.
module usb_rx_fifo #(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int AFULL = 48
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  usb_rx_fifo_if.slave    bus
);

  localparam logic [AW:0] FULL_LVL  = (AW+1)'(DEPTH);
  localparam logic [AW:0] AFULL_LVL = (AW+1)'(AFULL);
  localparam logic [AW:0] LVL_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   level_q;
  logic [AW:0]   level_nxt;
  logic          afull_q;
  logic          push;
  logic          pop;

  assign bus.in_rdy      = (level_q != FULL_LVL);
  assign bus.out_val     = (level_q != '0);
  assign bus.out_data    = mem[rd_ptr];
  assign bus.level       = level_q;
  assign bus.almost_full = afull_q;

  // A flush swallows any handshake that coincides with it.
  assign push = bus.in_val  & bus.in_rdy  & ~flush;
  assign pop  = bus.out_val & bus.out_rdy & ~flush;

  // Next occupancy: simultaneous push and pop leave the count unchanged.
  always_comb begin
    level_nxt = level_q;
    if (flush)             level_nxt = '0;
    else if (push && !pop) level_nxt = level_q + LVL_ONE;
    else if (pop && !push) level_nxt = level_q - LVL_ONE;
  end

  // Storage write; the array itself is never cleared.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.in_data;
  end

  // Pointers, level and the almost-full hint, all cleared by reset or flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      afull_q <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
      level_q <= level_nxt;
      afull_q <= (level_nxt >= AFULL_LVL);
    end
  end

endmodule
